// File: rtl/bus_pkg.sv
// Shared definitions for the load/store bus responder: widths, state
// encoding and the address decode helper.
package bus_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Low address bits that must be zero for a word access.
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT,
    ST_RESP = S_RESP
  } state_t;

  // True when addr is misaligned or outside [base, base+span). The limit is
  // computed one bit wider so a window ending at the top of the address
  // space does not wrap.
  function automatic logic addr_is_bad(input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] base,
                                       input logic [XLEN:0]   span);
    logic [XLEN:0] limit;
    limit = {1'b0, base} + span;
    addr_is_bad = ((addr & ALIGN_MASK) != 32'h0000_0000) ||
                  (addr < base) ||
                  ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Word-wide RAM with per-byte write enables and a registered read port,
// written so synthesis maps it onto block RAM.
module bus_mem_array import bus_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [STRB_W-1:0] we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] mem_r [DEPTH_WORDS];

  // Byte-masked write and read-first registered output; both only when enabled.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (we_i[b]) begin
          mem_r[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_o <= mem_r[addr_i];
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the core's load/store bus: accepts one request,
// waits WAIT_CYCLES, commits a byte-masked write or word read to the RAM,
// then holds the response until the core takes it.
module bus_mem_responder import bus_pkg::*; #(
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int              WAIT_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [STRB_W-1:0] req_wstrb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int            AW        = $clog2(DEPTH_WORDS);
  localparam int            SPAN_W    = XLEN + 1;
  localparam logic [XLEN:0] SPAN      = SPAN_W'(DEPTH_WORDS * 4);
  localparam bit            ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]    WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [XLEN-1:0]   addr_r;
  logic [XLEN-1:0]   wdata_r;
  logic [STRB_W-1:0] wstrb_r;
  logic              rd_ok_r;

  logic              accept_s;
  logic              commit_s;
  logic              op_we_s;
  logic [XLEN-1:0]   op_addr_s;
  logic [XLEN-1:0]   op_wdata_s;
  logic [STRB_W-1:0] op_wstrb_s;
  logic              op_err_s;
  logic              ram_en_s;
  logic [STRB_W-1:0] ram_we_s;
  logic [AW-1:0]     ram_addr_s;
  logic [XLEN-1:0]   ram_rdata_s;

  // Select the operation to commit: with no wait states the commit edge is
  // the accept edge, so the live request is used instead of the registers.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && req_valid_i && req_ready_o;
    if (state_r == ST_IDLE) begin
      op_we_s    = req_we_i;
      op_addr_s  = req_addr_i;
      op_wdata_s = req_wdata_i;
      op_wstrb_s = req_wstrb_i;
      commit_s   = accept_s && ZERO_WAIT;
    end else begin
      op_we_s    = we_r;
      op_addr_s  = addr_r;
      op_wdata_s = wdata_r;
      op_wstrb_s = wstrb_r;
      commit_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    end
    op_err_s   = addr_is_bad(op_addr_s, BASE_ADDR, SPAN);
    ram_en_s   = commit_s && !reset_i;
    ram_we_s   = (op_we_s && !op_err_s) ? op_wstrb_s : 4'b0000;
    ram_addr_s = AW'((op_addr_s - BASE_ADDR) >> 2);
  end

  bus_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .en_i    (ram_en_s),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (op_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // Read data is only exposed for a successful read; writes and errors give 0.
  always_comb begin
    if (rd_ok_r) begin
      rsp_rdata_o = ram_rdata_s;
    end else begin
      rsp_rdata_o = 32'h0000_0000;
    end
  end

  // Request/response FSM with wait counter and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rd_ok_r     <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      wstrb_r     <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            we_r        <= req_we_i;
            addr_r      <= req_addr_i;
            wdata_r     <= req_wdata_i;
            wstrb_r     <= req_wstrb_i;
            req_ready_o <= 1'b0;
            if (ZERO_WAIT) begin
              state_r     <= ST_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= op_err_s;
              rd_ok_r     <= !op_we_s && !op_err_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r     <= ST_RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= op_err_s;
            rd_ok_r     <= !op_we_s && !op_err_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_r     <= ST_IDLE;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rd_ok_r     <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 4'd0;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rd_ok_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: three instances with WAIT_CYCLES
// of 1, 3 and 0 share one clock and reset; one is exercised at a time.
module tb_bus_mem_responder;

  localparam int NI = 3;
  localparam int WAITS [NI] = '{1, 3, 0};

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_wstrb [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  exp_t        sb [$];
  logic [31:0] mdl [NI][1024];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bus_mem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_CYCLES (WAITS[g])
    ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_we_i    (req_we[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .req_wstrb_i (req_wstrb[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .rsp_err_o   (rsp_err[g])
    );
  end

  // Reference behaviour: 4 KiB window at 0, word aligned, byte-masked writes.
  function automatic exp_t model_access(int k, logic we, logic [31:0] addr,
                                        logic [31:0] wdata, logic [3:0] wstrb);
    exp_t e;
    e.err   = (addr[1:0] != 2'b00) || (addr >= 32'h0000_1000);
    e.rdata = 32'h0;
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mdl[k][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        e.rdata = mdl[k][addr[11:2]];
      end
    end
    return e;
  endfunction

  // Present a request at a negedge, wait for the accept edge, push the
  // expected response, then scramble the request lines.
  task automatic send_req(int k, logic we, logic [31:0] addr,
                          logic [31:0] wdata, logic [3:0] wstrb);
    int n = 0;
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_wstrb[k] = wstrb;
    req_valid[k] = 1'b1;
    while (req_ready[k] !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) begin
      n_chk++;
      $display("FAIL accept_timeout dut%0d: req_ready stayed %b", k, req_ready[k]);
    end
    @(posedge clk);
    sb.push_back(model_access(k, we, addr, wdata, wstrb));
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we[k]    = ~we;
    req_addr[k]  = 32'h0000_0044;
    req_wdata[k] = 32'hFFFF_FFFF;
    req_wstrb[k] = 4'hF;
  endtask

  // Wait for the response, compare it against the scoreboard, optionally
  // stall the handshake for 'stall' cycles while poking req_valid, then
  // complete the handshake.
  task automatic collect_rsp(int k, int stall, string nm);
    int   lat = 1;
    logic saw_ready = 1'b0;
    logic unstable = 1'b0;
    logic ready_leak = 1'b0;
    exp_t e;
    exp_t obs;
    while (rsp_valid[k] !== 1'b1 && lat < 60) begin
      if (req_ready[k] !== 1'b0) saw_ready = 1'b1;
      @(negedge clk); lat++;
    end
    e = sb.pop_front();
    n_chk++;
    if (lat != WAITS[k] + 1) $display("FAIL %s_latency dut%0d: got %0d cycles, want %0d", nm, k, lat, WAITS[k] + 1);
    else n_pass++;
    obs = {rsp_err[k], rsp_rdata[k]};
    n_chk++;
    if (obs !== e) $display("FAIL %s_data dut%0d: got err=%b rdata=%h, want err=%b rdata=%h", nm, k, obs.err, obs.rdata, e.err, e.rdata);
    else n_pass++;
    n_chk++;
    if (saw_ready || req_ready[k] !== 1'b0) $display("FAIL %s_busy dut%0d: req_ready high between accept and response", nm, k);
    else n_pass++;
    for (int i = 0; i < stall; i++) begin
      req_valid[k] = (i % 2 == 0); req_we[k] = 1'b0; req_addr[k] = 32'h0000_0030;
      @(negedge clk);
      if ({rsp_valid[k], rsp_err[k], rsp_rdata[k]} !== {1'b1, obs}) unstable = 1'b1;
      if (req_ready[k] !== 1'b0) ready_leak = 1'b1;
    end
    req_valid[k] = 1'b0;
    if (stall > 0) begin
      n_chk++;
      if (unstable || ready_leak) $display("FAIL %s_stall dut%0d: unstable=%b ready_leak=%b, want 0 0", nm, k, unstable, ready_leak);
      else n_pass++;
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    n_chk++;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) $display("FAIL %s_idle dut%0d: rsp_valid=%b req_ready=%b, want 0 1", nm, k, rsp_valid[k], req_ready[k]);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_chk++;
      if ({req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]} !== {1'b1, 1'b0, 1'b0, 32'h0})
        $display("FAIL reset_values dut%0d: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 0", k, req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]);
      else n_pass++;
      req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = 32'h0;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NI; k++) req_valid[k] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < NI; k++) begin
        if (c == 5) begin
          n_chk++;
          if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) $display("FAIL reset_wins dut%0d: valid=%b ready=%b, want 0 1", k, rsp_valid[k], req_ready[k]);
          else n_pass++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_word_rw();
    send_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF); collect_rsp(0, 0, "word_wr");
    send_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);         collect_rsp(0, 0, "word_rd");
  endtask

  task automatic test_strobes();
    send_req(0, 1'b1, 32'h0000_0010, 32'h0000_0055, 4'b0001); collect_rsp(0, 0, "strb1_wr");
    send_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);            collect_rsp(0, 0, "strb1_rd");
    send_req(0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000); collect_rsp(0, 0, "strb0_wr");
    send_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);            collect_rsp(0, 0, "strb0_rd");
    send_req(0, 1'b1, 32'h0000_0014, 32'hA1B2_C3D4, 4'b1010); collect_rsp(0, 0, "strb_a_wr");
  endtask

  task automatic test_errors();
    send_req(0, 1'b0, 32'h0000_0012, 32'h0, 4'h0);            collect_rsp(0, 0, "misalign_rd");
    send_req(0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF);    collect_rsp(0, 0, "base_wr");
    send_req(0, 1'b1, 32'h0000_1000, 32'h1111_1111, 4'hF);    collect_rsp(0, 0, "oor_wr");
    send_req(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0);            collect_rsp(0, 0, "base_rd");
    send_req(0, 1'b1, 32'h0000_0FFC, 32'h7654_3210, 4'hF);    collect_rsp(0, 0, "top_wr");
    send_req(0, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0);            collect_rsp(0, 0, "top_rd");
    send_req(0, 1'b1, 32'h0000_0012, 32'h2222_2222, 4'hF);    collect_rsp(0, 0, "misalign_wr");
  endtask

  task automatic test_backpressure();
    send_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    collect_rsp(0, 5, "bp_rd");
    send_req(0, 1'b0, 32'h0000_0030, 32'h0, 4'h0);
    collect_rsp(0, 0, "bp_after");
  endtask

  task automatic test_reset_midop();
    send_req(1, 1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF);
    collect_rsp(1, 0, "mid_init");
    send_req(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) $display("FAIL mid_reset: req_ready=%b rsp_valid=%b, want 1 0", req_ready[1], rsp_valid[1]);
    else n_pass++;
    void'(sb.pop_back());
    mdl[1][8] = 32'h0000_0000;
    send_req(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    collect_rsp(1, 0, "mid_rd");
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    int issued = 0;
    int got = 0;
    int last = -1;
    int cyc = 0;
    exp_t e;
    addrs = '{32'h40, 32'h44, 32'h48, 32'h4C};
    for (int i = 0; i < 4; i++) begin
      send_req(2, 1'b1, addrs[i], 32'h0BAD_0000 + 32'(i * 32'h1111), 4'hF);
      collect_rsp(2, 0, "b2b_fill");
    end
    rsp_ready[2] = 1'b1; req_we[2] = 1'b0; req_wstrb[2] = 4'h0;
    while (got < 4 && cyc < 40) begin
      if (rsp_valid[2] === 1'b1) begin
        e = sb.pop_front();
        n_chk++;
        if ({rsp_err[2], rsp_rdata[2]} !== e) $display("FAIL b2b_data[%0d]: got err=%b rdata=%h, want err=%b rdata=%h", got, rsp_err[2], rsp_rdata[2], e.err, e.rdata);
        else n_pass++;
        if (last >= 0) begin
          n_chk++;
          if (cyc - last != 2) $display("FAIL b2b_gap[%0d]: got %0d cycles, want 2", got, cyc - last);
          else n_pass++;
        end
        last = cyc;
        got++;
      end
      if (req_ready[2] === 1'b1 && issued < 4) begin
        req_addr[2] = addrs[issued]; req_valid[2] = 1'b1;
        sb.push_back(model_access(2, 1'b0, addrs[issued], 32'h0, 4'h0));
        issued++;
      end else if (req_ready[2] === 1'b1) begin
        req_valid[2] = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    req_valid[2] = 1'b0; rsp_ready[2] = 1'b0;
    n_chk++;
    if (got != 4) $display("FAIL b2b_count: got %0d responses, want 4", got);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'h0;
      req_wdata[k] = 32'h0; req_wstrb[k] = 4'h0; rsp_ready[k] = 1'b0;
      for (int w = 0; w < 1024; w++) mdl[k][w] = 32'h0;
    end
    @(negedge clk);
    test_reset();
    test_word_rw();
    test_strobes();
    test_errors();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
